// File: rtl/decode_eor_limit_unpack_pkg.sv
// Shared widths and constants for the JPEG-LS
// decoder-side EOR/limit bit unpacker.
package decode_eor_limit_unpack_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 7;
  localparam int BUF_W  = DATA_W + 8;

  localparam logic [7:0] STUFF_BYTE = 8'hFF;

  localparam logic [3:0] LEN_NONE    = 4'd0;
  localparam logic [3:0] LEN_STUFFED = 4'd7;
  localparam logic [3:0] LEN_FULL    = 4'd8;

endpackage

// File: rtl/decode_eor_limit_unpack_destuffer.sv
// Marker bit-stuffing removal: turns one stream
// byte into 0/7/8 MSB-aligned payload bits.
module jpegls_byte_destuffer
  import decode_eor_limit_unpack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       take,
  input  logic [7:0] byte_in,
  output logic [7:0] append_bits,
  output logic [3:0] append_len,
  output logic       marker_found,
  output logic [7:0] marker_byte
);

  logic ff_pending;

  // payload of the byte being taken this cycle
  always_comb begin
    append_bits = 8'h00;
    append_len  = LEN_NONE;
    if (take) begin
      if (!ff_pending) begin
        append_bits = byte_in;
        append_len  = LEN_FULL;
      end else if (!byte_in[7]) begin
        append_bits = {byte_in[6:0], 1'b0};
        append_len  = LEN_STUFFED;
      end
    end
  end

  // stuffing flag and sticky marker capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_pending   <= 1'b0;
      marker_found <= 1'b0;
      marker_byte  <= 8'h00;
    end else if (clear) begin
      ff_pending   <= 1'b0;
      marker_found <= 1'b0;
      marker_byte  <= 8'h00;
    end else if (take) begin
      ff_pending <= !ff_pending &&
                    (byte_in == STUFF_BYTE);
      if (ff_pending && byte_in[7]) begin
        marker_found <= 1'b1;
        marker_byte  <= byte_in;
      end
    end
  end

endmodule

// File: rtl/decode_eor_limit_unpack.sv
// MSB-aligned bit window fed by destuffed bytes
// and drained by variable-length consumes.
module decode_eor_limit_unpack
  import decode_eor_limit_unpack_pkg::*;
#(
  parameter int dataOut_length      = DATA_W,
  parameter int encodedlength_width = CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  output logic                           byte_ready,
  output logic [dataOut_length-1:0]      window,
  output logic [encodedlength_width-1:0] bit_count,
  input  logic [encodedlength_width-1:0] consume_len,
  input  logic                           consume_valid,
  output logic                           consume_ready,
  output logic                           marker_found,
  output logic [7:0]                     marker_byte
);

  localparam int BW = dataOut_length + 8;
  localparam logic [encodedlength_width-1:0]
    MAX_CONS = encodedlength_width'(dataOut_length);

  logic [BW-1:0] shift_buf;
  logic [BW-1:0] shifted;
  logic [BW-1:0] placed;
  logic [BW-1:0] buf_next;

  logic [encodedlength_width-1:0] cons_amt;
  logic [encodedlength_width-1:0] remain;
  logic [encodedlength_width-1:0] count_next;

  logic       accept;
  logic       do_cons;
  logic [7:0] append_bits;
  logic [3:0] append_len;

  assign byte_ready = (bit_count <= MAX_CONS) &&
                      !marker_found && !reset;
  assign consume_ready = (consume_len <= bit_count) &&
                         (consume_len <= MAX_CONS);
  assign accept  = byte_valid && byte_ready;
  assign do_cons = consume_valid && consume_ready;
  assign window  = shift_buf[BW-1 -: dataOut_length];

  jpegls_byte_destuffer u_destuff (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .take         (accept),
    .byte_in      (byte_in),
    .append_bits  (append_bits),
    .append_len   (append_len),
    .marker_found (marker_found),
    .marker_byte  (marker_byte)
  );

  // drop consumed bits, then merge new bits just below the survivors
  always_comb begin
    cons_amt   = do_cons ? consume_len : '0;
    remain     = bit_count - cons_amt;
    shifted    = shift_buf << cons_amt;
    placed     = {append_bits, {dataOut_length{1'b0}}}
                 >> remain;
    buf_next   = shifted | placed;
    count_next = remain +
                 encodedlength_width'(append_len);
  end

  // window storage; clear beats any same-cycle traffic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_buf <= '0;
      bit_count <= '0;
    end else if (clear) begin
      shift_buf <= '0;
      bit_count <= '0;
    end else begin
      shift_buf <= buf_next;
      bit_count <= count_next;
    end
  end

endmodule

// File: tb/tb_decode_eor_limit_unpack.sv
// Randomized bench for decode_eor_limit_unpack
// against a bit-queue reference model.
module tb_decode_eor_limit_unpack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [63:0] window;
  logic [6:0]  bit_count;
  logic [6:0]  consume_len = 7'd0;
  logic        consume_valid = 1'b0;
  logic        consume_ready;
  logic        marker_found;
  logic [7:0]  marker_byte;

  int checks = 0;
  int errors = 0;

  bit         mq[$];
  bit         m_ff;
  bit         m_mk;
  logic [7:0] m_mb;

  decode_eor_limit_unpack dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .window        (window),
    .bit_count     (bit_count),
    .consume_len   (consume_len),
    .consume_valid (consume_valid),
    .consume_ready (consume_ready),
    .marker_found  (marker_found),
    .marker_byte   (marker_byte)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_window();
    logic [63:0] w = '0;
    for (int i = 0; i < 64 && i < mq.size(); i++)
      w[63-i] = mq[i];
    return w;
  endfunction

  function automatic logic m_cready(input int cl);
    return (cl <= mq.size()) && (cl <= 64);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ff = 1'b0;
    m_mk = 1'b0;
    m_mb = 8'h00;
  endtask

  task automatic m_edge();
    bit acc;
    if (clear) begin
      m_reset();
      return;
    end
    acc = byte_valid && (mq.size() <= 64) && !m_mk;
    if (consume_valid && m_cready(int'(consume_len)))
      repeat (int'(consume_len)) void'(mq.pop_front());
    if (acc) begin
      if (!m_ff) begin
        for (int i = 7; i >= 0; i--) mq.push_back(byte_in[i]);
        m_ff = (byte_in == 8'hFF);
      end else if (!byte_in[7]) begin
        for (int i = 6; i >= 0; i--) mq.push_back(byte_in[i]);
        m_ff = 1'b0;
      end else begin
        m_mk = 1'b1;
        m_mb = byte_in;
        m_ff = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("window", window, m_window());
    chk("bit_count", bit_count, mq.size());
    chk("byte_ready", byte_ready,
        (mq.size() <= 64) && !m_mk);
    chk("consume_ready", consume_ready,
        m_cready(int'(consume_len)));
    chk("marker_found", marker_found, m_mk);
    chk("marker_byte", marker_byte, m_mb);
  endtask

  task automatic cyc(input logic bv, input logic [7:0] b,
                     input logic cv, input logic [6:0] cl,
                     input logic clr);
    byte_valid    = bv;
    byte_in       = b;
    consume_valid = cv;
    consume_len   = cl;
    clear         = clr;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_count", bit_count, 0);
    chk("rst_window", window, 0);
    chk("rst_marker", marker_found, 1'b0);
    reset = 1'b0;
    #1;
    compare_all();
    chk("rel_ready", byte_ready, 1'b1);

    cyc(1, 8'hA5, 0, 0, 0);
    cyc(1, 8'h3C, 0, 0, 0);
    chk("tp1_count", bit_count, 16);
    chk("tp1_window", window, {16'hA53C, 48'h0});

    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hFF, 0, 0, 0);
    cyc(1, 8'h45, 0, 0, 0);
    chk("tp2_count", bit_count, 15);
    chk("tp2_window", window,
        {8'hFF, 7'b1000101, 49'h0});

    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hFF, 0, 0, 0);
    cyc(1, 8'hD9, 0, 0, 0);
    chk("tp3_count", bit_count, 8);
    chk("tp3_marker", marker_found, 1'b1);
    chk("tp3_mbyte", marker_byte, 8'hD9);
    chk("tp3_ready", byte_ready, 1'b0);
    cyc(0, 8'h00, 0, 0, 1);
    chk("tp3_clr_count", bit_count, 0);
    chk("tp3_clr_ready", byte_ready, 1'b1);

    for (int i = 0; i < 9; i++) cyc(1, 8'h11, 0, 0, 0);
    chk("tp4_full_ready", byte_ready, 1'b0);
    chk("tp4_full_count", bit_count, 72);
    cyc(0, 8'h00, 1, 7'd8, 0);
    chk("tp4_count", bit_count, 64);
    chk("tp4_ready", byte_ready, 1'b1);

    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hA5, 0, 0, 0);
    cyc(1, 8'h3C, 0, 0, 0);
    cyc(1, 8'h81, 1, 7'd5, 0);
    chk("tp5_count", bit_count, 19);
    chk("tp5_window", window,
        {11'h53C, 8'h81, 45'h0});

    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hA5, 0, 0, 0);
    cyc(1, 8'h3C, 0, 0, 0);
    consume_len   = 7'd20;
    consume_valid = 1'b1;
    byte_valid    = 1'b0;
    #1;
    chk("tp6_cready", consume_ready, 1'b0);
    cyc(0, 8'h00, 1, 7'd20, 0);
    chk("tp6_count", bit_count, 16);
    chk("tp6_window", window, {16'hA53C, 48'h0});

    cyc(0, 8'h00, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] b;
      logic [6:0] cl;
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 15) == 0)
        cl = 7'($urandom_range(0, 127));
      else
        cl = 7'($urandom_range(0, 20));
      cyc(1'($urandom_range(0, 3) != 0), b,
          1'($urandom_range(0, 9) < 7), cl,
          1'($urandom_range(0, 24) == 0));
    end

    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'h12, 0, 0, 0);
    cyc(1, 8'hFF, 0, 0, 0);
    byte_in    = 8'hC0;
    byte_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    chk("mrst_count", bit_count, 0);
    chk("mrst_window", window, 0);
    chk("mrst_ready", byte_ready, 1'b0);
    chk("mrst_marker", marker_found, 1'b0);
    chk("mrst_mbyte", marker_byte, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 8'hC0, 0, 0, 0);
    chk("post_rst_count", bit_count, 8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_eor_limit_unpack.md
# decode_eor_limit_unpack

Decoder-side bit unpacker for run-interruption limit-overflow coding: the receive-end counterpart of the encoder's byte-packing/overflow split. Accepts the byte-packed JPEG-LS scan stream one byte at a time, removes marker bit-stuffing, and keeps an MSB-aligned bit window from which the run-interruption decoder consumes variable-length codes. It sits between the byte input FIFO and the EOR/limit code parser.

## Interface
- dataOut_length, 64, width of the presented bit window (bits)
- encodedlength_width, 7, width of length/count fields; must hold dataOut_length+8
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous flush to empty; also clears marker_found
- byte_in  in  8  next stream byte, MSB first
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  byte accepted on edge when valid&ready
- window  out  dataOut_length  next undecoded bits, MSB-aligned, zero-filled below bit_count
- bit_count  out  encodedlength_width  valid bits held, 0..dataOut_length+8
- consume_len  in  encodedlength_width  bits to drop, 1..dataOut_length
- consume_valid  in  1  consume request
- consume_ready  out  1  consume_len <= bit_count (current, registered count)
- marker_found  out  1  sticky: 0xFF followed by byte with MSB=1
- marker_byte  out  8  the offending byte after 0xFF

## Operation
- Internal buffer: dataOut_length+8 bits, MSB-aligned; window = top dataOut_length bits.
- byte_ready = (bit_count <= dataOut_length) & !marker_found & !reset.
- Destuffing, flag ff_pending:
  - ff_pending=0: append all 8 bits; ff_pending <= (byte_in==8'hFF).
  - ff_pending=1, byte_in[7]=0: append byte_in[6:0] (7 bits); ff_pending <= 0.
  - ff_pending=1, byte_in[7]=1: nothing appended; marker_found<=1, marker_byte<=byte_in; ff_pending<=0.
- Consume: when consume_valid & consume_ready, shift buffer left by consume_len, bit_count -= consume_len.
- Same-cycle consume and append: both take effect; appended bits land at position (bit_count - consume_len) from MSB; bit_count_next = bit_count - consume_len + appended.
- consume_len = 0 is a no-op; consume_len > dataOut_length never ready.
- Bits below bit_count always zero (never stale data).
- marker_found stops input; consumption of buffered bits continues; only clear or reset resumes.

## Timing
- Reset values: window 0, bit_count 0, marker_found 0, marker_byte 0, ff_pending 0, byte_ready 0 during reset, 1 first cycle after release.
- Byte accepted at edge N appears in window/bit_count after edge N (visible cycle N+1).
- consume_ready combinational from registered bit_count and consume_len; window updated edge after consume.
- Sustained throughput: one byte and one consume per cycle.
- Full: bit_count > dataOut_length -> byte_ready low; frees same cycle the count drops.
- clear concurrent with byte or consume: clear wins, both dropped.
- Reset mid-stream: all state lost immediately (async), no partial byte retained.

## Structure
- Shared package: window/count widths, STUFF_BYTE=8'hFF, max buffer width constant.
- One sub-module: jpegls_byte_destuffer (ff_pending, marker detect, outputs append_bits[7:0] and append_len 0/7/8).
- Top: buffer register, shift/merge datapath, count arithmetic, handshakes.

## Test plan
- Bytes 8'hA5, 8'h3C, no consume -> bit_count 16, window top 16 = 16'hA53C, rest 0.
- Bytes 8'hFF, 8'h45 -> bit_count 15, window top 15 = 1111_1111_100_0101; ff_pending cleared.
- Bytes 8'hFF, 8'hD9 -> bit_count 8, marker_found 1, marker_byte 8'hD9, byte_ready 0; clear -> bit_count 0, ready 1.
- Fill 9 bytes (72 bits) -> byte_ready 0; consume_len 8 -> bit_count 64, ready 1 next cycle.
- bit_count 16, same cycle consume_len 5 and byte 8'h81 -> bit_count 19, window top 19 = old bits[10:0] then 8'h81.
- consume_len 20 with bit_count 16 -> consume_ready 0, state unchanged; assert reset mid-stream -> all outputs to reset values.
